// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: port indices, owner FSM
// encoding, lane count and the burst counter width helper.
package dmem_pkg;

    localparam int DMEM_P_CORE = 0;
    localparam int DMEM_P_DMA  = 1;
    localparam int DMEM_LANES  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } owner_t;

    // Width needed to hold a burst count of 0..max_burst.
    function automatic int burst_cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant picker for the data-memory arbiter.
// Optional feature: define DMEM_ARB_RR_EN to break two-way ties round-robin
// (against the last granted port) instead of fixed priority to port 0.
module dmem_arb_pick
    import dmem_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = burst_cnt_width(MAX_BURST)
) (
    input  logic             req0,
    input  logic             req1,
    input  owner_t           owner,
    input  logic [CNT_W-1:0] burst_cnt,
    input  logic             last,
    output logic             gnt0,
    output logic             gnt1
);

    logic burst_full;
    logic tie_to_1;

    assign burst_full = (burst_cnt == CNT_W'(MAX_BURST));

`ifdef DMEM_ARB_RR_EN
    assign tie_to_1 = (last == 1'(DMEM_P_CORE));
`else
    logic unused_last;
    assign unused_last = last;
    assign tie_to_1    = 1'b0;
`endif

    // Resolve a two-way request: tie rule first, then force a hand-over once the owner used up its burst.
    always_comb begin
        logic pick1;
        pick1 = tie_to_1;
        if (burst_full && owner == ST_OWN0) begin
            pick1 = 1'b1;
        end else if (burst_full && owner == ST_OWN1) begin
            pick1 = 1'b0;
        end
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            gnt0 = ~pick1;
            gnt1 = pick1;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the four byte-lane data BRAMs (core LSU on
// port 0, DMA/debug loader on port 1). One access per cycle, read data
// returned one cycle after the grant, bursts bounded to avoid starvation.
// Optional feature macro: DMEM_ARB_RR_EN (round-robin tie breaking).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int MAX_BURST  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  P0_REQ,
    input  logic                  P0_WE,
    input  logic [ADDR_WIDTH-1:0] P0_ADDR,
    input  logic [31:0]           P0_WDATA,
    input  logic [DMEM_LANES-1:0] P0_BE,
    output logic                  P0_GNT,
    output logic                  P0_RVALID,
    output logic [31:0]           P0_RDATA,
    input  logic                  P1_REQ,
    input  logic                  P1_WE,
    input  logic [ADDR_WIDTH-1:0] P1_ADDR,
    input  logic [31:0]           P1_WDATA,
    input  logic [DMEM_LANES-1:0] P1_BE,
    output logic                  P1_GNT,
    output logic                  P1_RVALID,
    output logic [31:0]           P1_RDATA,
    output logic [ADDR_WIDTH-1:0] M_W_ADDR,
    output logic [ADDR_WIDTH-1:0] M_R_ADDR,
    output logic [DMEM_LANES-1:0] M_WRITE_EN,
    output logic [DMEM_LANES-1:0] M_READ_EN,
    output logic [31:0]           M_DIN,
    input  logic [31:0]           M_DOUT
);

    localparam int CNT_W = burst_cnt_width(MAX_BURST);

    owner_t                owner;
    logic [CNT_W-1:0]      burst_cnt;
    logic                  last;
    logic                  pick0;
    logic                  pick1;
    logic                  any_gnt;
    owner_t                gnt_owner;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [31:0]           sel_wdata;
    logic [DMEM_LANES-1:0] sel_be;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic [31:0]           din_hold;

    dmem_arb_pick #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_pick (
        .req0      (P0_REQ),
        .req1      (P1_REQ),
        .owner     (owner),
        .burst_cnt (burst_cnt),
        .last      (last),
        .gnt0      (pick0),
        .gnt1      (pick1)
    );

    // Grants are suppressed while reset is high so no lane can be written during reset.
    assign P0_GNT    = pick0 & ~RST;
    assign P1_GNT    = pick1 & ~RST;
    assign any_gnt   = P0_GNT | P1_GNT;
    assign gnt_owner = P1_GNT ? ST_OWN1 : ST_OWN0;

    // Route the granted port's fields to the lanes; idle cycles keep the last address and data.
    always_comb begin
        sel_we     = P1_GNT ? P1_WE    : P0_WE;
        sel_addr   = P1_GNT ? P1_ADDR  : P0_ADDR;
        sel_wdata  = P1_GNT ? P1_WDATA : P0_WDATA;
        sel_be     = P1_GNT ? P1_BE    : P0_BE;
        M_WRITE_EN = '0;
        M_READ_EN  = '0;
        M_W_ADDR   = addr_hold;
        M_R_ADDR   = addr_hold;
        M_DIN      = din_hold;
        if (any_gnt) begin
            M_W_ADDR = sel_addr;
            M_R_ADDR = sel_addr;
            M_DIN    = sel_wdata;
            if (sel_we) begin
                M_WRITE_EN = sel_be;
            end else begin
                M_READ_EN = {DMEM_LANES{1'b1}};
            end
        end
    end

    // Remember the last issued address and data so the lanes see stable values when idle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_hold <= '0;
            din_hold  <= '0;
        end else if (any_gnt) begin
            addr_hold <= sel_addr;
            din_hold  <= sel_wdata;
        end
    end

    // Owner FSM: tracks who holds the lanes, how long they have held them and who went last.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            owner     <= ST_IDLE;
            burst_cnt <= '0;
            last      <= 1'(DMEM_P_DMA);
        end else if (any_gnt) begin
            last <= P1_GNT ? 1'(DMEM_P_DMA) : 1'(DMEM_P_CORE);
            if (owner == gnt_owner) begin
                if (burst_cnt != CNT_W'(MAX_BURST)) begin
                    burst_cnt <= burst_cnt + CNT_W'(1);
                end
            end else begin
                owner     <= gnt_owner;
                burst_cnt <= CNT_W'(1);
            end
        end else begin
            owner     <= ST_IDLE;
            burst_cnt <= '0;
        end
    end

    // Read return: lanes captured on the negedge of the grant cycle, so register their output here.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            P0_RVALID <= 1'b0;
            P1_RVALID <= 1'b0;
            P0_RDATA  <= '0;
            P1_RDATA  <= '0;
        end else begin
            P0_RVALID <= P0_GNT & ~P0_WE;
            P1_RVALID <= P1_GNT & ~P1_WE;
            if (P0_GNT && !P0_WE) begin
                P0_RDATA <= M_DOUT;
            end
            if (P1_GNT && !P1_WE) begin
                P1_RDATA <= M_DOUT;
            end
        end
    end

endmodule
